vgta_avg_fifo: RTL and testbench
================================

Name: vgta_avg_fifo

Overview:
- Downstream consumer of the VGTA measurement stage.
- Accepts each 8-bit measurement word (Dout) together with its measurement-done strobe.
- Averages every 2^LOG2N consecutive samples (block average, no overlap).
- Buffers the averaged words in a small show-ahead FIFO, drained by a valid/ready handshake toward the readout/display logic.

Parameters:
- DW, 8, data width of input samples and averaged output.
- LOG2N, 2, log2 of samples per average (4 samples by default).
- DEPTH, 4, FIFO depth in words; must be a power of 2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- clr  input  1  asynchronous active-high reset.
- Start  input  1  averaging enable, level-sensitive; same signal that enables VGTA.
- din  input  DW  measurement word (VGTA Dout).
- din_valid  input  1  single-cycle strobe: din holds a new measurement.
- dout  output  DW  averaged word at FIFO head.
- dout_valid  output  1  FIFO not empty.
- dout_ready  input  1  consumer accepts dout this cycle.
- fifo_cnt  output  log2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: an average was dropped because the FIFO was full.

Behaviour:
- Reset (clr=1, async):
  - state=IDLE; accumulator=0; sample counter=0.
  - FIFO pointers=0; dout=0, dout_valid=0, fifo_cnt=0, overflow=0.
- Accumulator width DW+LOG2N; it cannot overflow.
- Sample counter width LOG2N (wraps).
- State IDLE:
  - accumulator and counter held at 0; din_valid ignored.
  - Start=1 moves to ACCUM next cycle.
  - A rising edge of Start also clears overflow.
- State ACCUM:
  - On din_valid=1 with counter < N-1: acc += din, counter += 1.
  - On din_valid=1 with counter = N-1 (Nth sample): avg = (acc + din) >> LOG2N, truncated, not rounded.
    - avg is written into the FIFO at that same edge.
    - acc and counter return to 0; the next din_valid starts a new block.
  - Start=0 returns to IDLE next cycle. A partially accumulated block is discarded. FIFO contents are kept and remain drainable.
- Latency: dout_valid rises on the cycle after the edge that captures the Nth sample (when the FIFO was empty). dout then equals avg.
- FIFO behaviour:
  - Show-ahead: dout = mem[rd_ptr] whenever dout_valid=1.
  - dout holds its last value when empty.
  - Pop occurs when dout_valid & dout_ready; dout_ready while empty has no effect.
- Push while full:
  - Without a simultaneous pop: the word is dropped, overflow is set, and FIFO contents are unchanged.
  - With a simultaneous pop: push is accepted, fifo_cnt stays DEPTH, no overflow.
- Push and pop on the same cycle when not empty and not full: fifo_cnt unchanged.
- Pointers wrap modulo DEPTH. fifo_cnt is tracked explicitly; full when fifo_cnt=DEPTH.
- overflow is sticky. It clears only on clr or a Start rising edge.
- din_valid in consecutive cycles is legal; every strobe is counted.
- clr asserted mid-block or with a non-empty FIFO: everything clears immediately (async). The first post-reset average needs a full N new samples.

Test Plan:
- Reset then Start=1; din 10,20,30,41 with din_valid pulses, dout_ready=0 -> one cycle after the 4th strobe: dout_valid=1, dout=25 (101>>2), fifo_cnt=1.
- din=255 x4 back-to-back strobes -> dout=255, no accumulator wrap. Then din=0,0,0,3 -> second word=0, fifo_cnt=2.
- Five blocks with dout_ready=0 -> fifo_cnt=4 after block 4; block 5 dropped, overflow=1; dout still shows block 1. Start low then high -> overflow=0.
- FIFO full, dout_ready=1 on the same cycle as the 4th strobe of a new block -> one pop and one push, fifo_cnt stays 4, overflow stays 0, new word appears last in drain order.
- 2 samples accumulated, Start dropped, Start raised, then 4 samples of 8 -> output 8 (partial block discarded); earlier FIFO words remain intact.
- clr pulsed mid-block with fifo_cnt=3 -> dout_valid=0, fifo_cnt=0, overflow=0 immediately. The next average requires 4 fresh strobes.

Source files
------------

// File: rtl/vgta_avg_fifo_if.sv
// ============================================================================
// Module   : vgta_avg_fifo_if
// Purpose  : Sample-in / averaged-word-out bundle of the VGTA averaging FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vgta_avg_fifo_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             din_valid;
    logic [DW-1:0]    din;
    logic [DW-1:0]    dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [CNT_W-1:0] fifo_cnt;
    logic             overflow;

    // Producer of samples and consumer of averages
    modport master (
        output din,
        output din_valid,
        output dout_ready,
        input  dout,
        input  dout_valid,
        input  fifo_cnt,
        input  overflow
    );

    // The averaging FIFO itself
    modport slave (
        input  din,
        input  din_valid,
        input  dout_ready,
        output dout,
        output dout_valid,
        output fifo_cnt,
        output overflow
    );
endinterface

`default_nettype wire

// File: rtl/vgta_avg_fifo.sv
// ============================================================================
// Module   : vgta_avg_fifo
// Purpose  : Block-averages 2^LOG2N VGTA samples and queues the averages in a
//            show-ahead FIFO drained by a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vgta_avg_fifo #(
    parameter int DW    = 8,
    parameter int LOG2N = 2,
    parameter int DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         clr,
    input  wire logic         Start,
    vgta_avg_fifo_if.slave    bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ACC_W = DW + LOG2N;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    localparam logic [LOG2N-1:0] LAST_SAMPLE = '1;
    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [0:0] state;
    logic [0:0] state_nxt;
    logic       accept;
    logic       acc_clear;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Start)  state_nxt = S_ACCUM;
            S_ACCUM: if (!Start) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        accept    = 1'b0;
        acc_clear = 1'b0;
        case (state)
            S_IDLE:  acc_clear = 1'b1;
            S_ACCUM: accept    = bus.din_valid;
            default: acc_clear = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator: wide enough for N full-scale samples, so no wrap
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc;
    logic [LOG2N-1:0] sample_cnt;
    logic [ACC_W-1:0] sum;
    logic [DW-1:0]    avg;
    logic             last_sample;

    assign sum         = acc + ACC_W'(bus.din);
    assign avg         = sum[ACC_W-1:LOG2N];
    assign last_sample = accept && (sample_cnt == LAST_SAMPLE);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            acc        <= '0;
            sample_cnt <= '0;
        end else if (acc_clear) begin
            acc        <= '0;
            sample_cnt <= '0;
        end else if (accept) begin
            if (last_sample) begin
                acc        <= '0;
                sample_cnt <= '0;
            end else begin
                acc        <= sum;
                sample_cnt <= sample_cnt + LOG2N'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Start edge detector (clears the sticky overflow)
    // ------------------------------------------------------------------
    logic start_d;
    logic start_rise;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            start_d <= 1'b0;
        end else begin
            start_d <= Start;
        end
    end

    assign start_rise = Start && !start_d;

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    last_dout;
    logic             ovf;
    logic             empty;
    logic             full;
    logic             pop;
    logic             wr_en;
    logic             drop;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    assign pop   = !empty && bus.dout_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign wr_en = last_sample && (!full || pop);
    assign drop  = last_sample && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= avg;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Keeps the most recently popped word so dout holds steady while empty
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            last_dout <= '0;
        end else if (pop) begin
            last_dout <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (start_rise) begin
            ovf <= 1'b0;
        end
    end

    assign bus.dout       = empty ? last_dout : mem[rd_ptr];
    assign bus.dout_valid = !empty;
    assign bus.fifo_cnt   = cnt;
    assign bus.overflow   = ovf;

endmodule

`default_nettype wire

// File: tb/tb_vgta_avg_fifo.sv
// ============================================================================
// Module   : tb_vgta_avg_fifo
// Purpose  : Directed scoreboard bench for vgta_avg_fifo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vgta_avg_fifo;

    localparam int DW    = 8;
    localparam int LOG2N = 2;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic clr   = 1'b1;
    logic Start = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q [$];

    vgta_avg_fifo_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    vgta_avg_fifo #(.DW(DW), .LOG2N(LOG2N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .clr   (clr),
        .Start (Start),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every accepted word is compared against the scoreboard head
    always @(negedge clk) begin
        if (!clr && bus.dout_valid && bus.dout_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %0d expected none", bus.dout);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(bus.dout) != e) begin
                    n_fail++;
                    $display("FAIL pop_data: got %0d expected %0d", bus.dout, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int v);
        bus.din       = DW'(v);
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
    endtask

    task automatic blk(input int a, input int b, input int c, input int d);
        strobe(a);
        strobe(b);
        strobe(c);
        strobe(d);
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus.dout_ready = 1'b1;
        while (bus.fifo_cnt != 0 && k < 20) begin
            tick();
            k++;
        end
        bus.dout_ready = 1'b0;
        chk("drain_empty", int'(bus.fifo_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", int'(bus.dout_valid), 0);
        chk("rst_cnt",   int'(bus.fifo_cnt),   0);
        chk("rst_ovf",   int'(bus.overflow),   0);
        chk("rst_dout",  int'(bus.dout),       0);
        clr = 1'b0;
        tick();

        // Basic block average: 101 >> 2 = 25
        Start = 1'b1;
        tick();
        strobe(10);
        strobe(20);
        strobe(30);
        chk("t1_not_yet", int'(bus.dout_valid), 0);
        strobe(41);
        chk("t1_valid", int'(bus.dout_valid), 1);
        chk("t1_dout",  int'(bus.dout),       25);
        chk("t1_cnt",   int'(bus.fifo_cnt),   1);
        exp_q.push_back(25);
        drain();
        chk("t1_hold_valid", int'(bus.dout_valid), 0);
        chk("t1_hold_dout",  int'(bus.dout),       25);

        // Full-scale block and a truncating block
        blk(255, 255, 255, 255);
        exp_q.push_back(255);
        blk(0, 0, 0, 3);
        exp_q.push_back(0);
        chk("t2_head", int'(bus.dout),     255);
        chk("t2_cnt",  int'(bus.fifo_cnt), 2);
        drain();

        // Fill to DEPTH, fifth block dropped
        blk(4, 4, 4, 4);        exp_q.push_back(4);
        blk(8, 8, 8, 9);        exp_q.push_back(8);
        blk(1, 2, 3, 4);        exp_q.push_back(2);
        blk(100, 100, 100, 100); exp_q.push_back(100);
        chk("t3_cnt4", int'(bus.fifo_cnt), 4);
        chk("t3_ovf0", int'(bus.overflow), 0);
        blk(7, 7, 7, 7);
        chk("t3_cnt_full", int'(bus.fifo_cnt), 4);
        chk("t3_ovf1",     int'(bus.overflow), 1);
        chk("t3_head",     int'(bus.dout),     4);
        Start = 1'b0;
        tick();
        chk("t3_ovf_sticky", int'(bus.overflow), 1);
        Start = 1'b1;
        tick();
        chk("t3_ovf_clr", int'(bus.overflow), 0);
        chk("t3_kept",    int'(bus.fifo_cnt), 4);

        // Push and pop together while full: 83 >> 2 = 20
        strobe(20);
        strobe(20);
        strobe(20);
        bus.din        = 8'd23;
        bus.din_valid  = 1'b1;
        bus.dout_ready = 1'b1;
        tick();
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        exp_q.push_back(20);
        chk("t4_cnt",  int'(bus.fifo_cnt), 4);
        chk("t4_ovf",  int'(bus.overflow), 0);
        chk("t4_head", int'(bus.dout),     8);
        drain();

        // Partial block discarded on Start drop; strobe in IDLE ignored
        blk(50, 50, 50, 50);
        exp_q.push_back(50);
        strobe(200);
        strobe(200);
        Start = 1'b0;
        tick();
        strobe(99);
        Start = 1'b1;
        tick();
        blk(8, 8, 8, 8);
        exp_q.push_back(8);
        chk("t5_cnt",  int'(bus.fifo_cnt), 2);
        chk("t5_head", int'(bus.dout),     50);
        drain();

        // Asynchronous clear mid-block with three words queued
        blk(12, 12, 12, 12); exp_q.push_back(12);
        blk(16, 16, 16, 16); exp_q.push_back(16);
        blk(40, 40, 40, 40); exp_q.push_back(40);
        chk("t6_cnt3", int'(bus.fifo_cnt), 3);
        strobe(9);
        strobe(9);
        #2;
        clr = 1'b1;
        #1;
        chk("t6_clr_valid", int'(bus.dout_valid), 0);
        chk("t6_clr_cnt",   int'(bus.fifo_cnt),   0);
        chk("t6_clr_ovf",   int'(bus.overflow),   0);
        exp_q.delete();
        tick();
        clr = 1'b0;
        tick();
        strobe(60);
        strobe(60);
        strobe(60);
        chk("t6_fresh_pending", int'(bus.dout_valid), 0);
        chk("t6_fresh_cnt0",    int'(bus.fifo_cnt),   0);
        strobe(64);
        chk("t6_fresh_valid", int'(bus.dout_valid), 1);
        chk("t6_fresh_dout",  int'(bus.dout),       61);
        chk("t6_fresh_cnt",   int'(bus.fifo_cnt),   1);
        exp_q.push_back(61);
        drain();
        tick();
        chk("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
